sub_bytes_lanes: RTL

Parametrised, fully pipelined AES SubBytes/InvSubBytes engine for LANES byte lanes per beat.
- Replaces the fixed 4-lane, pulse-driven word substitution used by round and key-expansion logic.
- Adds valid/ready backpressure, a per-beat mode, a per-lane bypass mask and a sideband tag.
- Sits between AddRoundKey/ShiftRows stages, and in the key scheduler for SubWord.

---
 rtl/aes_sbox_pkg.sv | 52 +++++
 rtl/sbox_lut.sv | 21 ++
 rtl/sub_bytes_lanes.sv | 108 ++++++++++
 3 files changed

// File: rtl/aes_sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_pkg
// Description : AES forward and inverse S-box tables shared by the byte
//               substitution datapath and anything else needing SubBytes.
//               Contents: BYTE_W (byte width), SBOX[256], INV_SBOX[256].
// Revision    : 1.0 - initial release
// ============================================================================
package aes_sbox_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage
`default_nettype wire

// File: rtl/sbox_lut.sv
`default_nettype none
// ============================================================================
// Module      : sbox_lut
// Description : Combinational single-byte AES S-box / inverse S-box lookup.
//               value   - byte to substitute
//               encrypt - 1 selects SBOX, 0 selects INV_SBOX
//               result  - substituted byte
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_lut
  import aes_sbox_pkg::*;
(
  input  logic [BYTE_W-1:0] value,
  input  logic              encrypt,
  output logic [BYTE_W-1:0] result
);

  assign result = encrypt ? SBOX[value] : INV_SBOX[value];

endmodule
`default_nettype wire

// File: rtl/sub_bytes_lanes.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_lanes
// Description : Two-stage valid/ready pipeline applying SubBytes or
//               InvSubBytes to LANES byte lanes per beat, with a per-lane
//               bypass mask and an opaque sideband tag.
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data/in_encrypt/in_mask/in_tag : input beat
//   out_valid/out_ready/out_data/out_tag                : output beat
//   inflight                                            : beats held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_lanes
  import aes_sbox_pkg::*;
#(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W*LANES-1:0]   in_data,
  input  logic                      in_encrypt,
  input  logic [LANES-1:0]          in_mask,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTE_W*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic [1:0]                inflight
);

  logic                    live;
  logic                    s1_valid;
  logic                    s1_encrypt;
  logic [BYTE_W*LANES-1:0] s1_data;
  logic [LANES-1:0]        s1_mask;
  logic [TAG_W-1:0]        s1_tag;
  logic                    out_adv;
  logic                    s1_adv;
  logic                    accept;
  logic [BYTE_W*LANES-1:0] lane_result;

  assign out_adv  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || out_adv;
  // live keeps in_ready low while reset is asserted, even though the
  // empty pipe would otherwise report that it can advance.
  assign in_ready = live && s1_adv;
  assign accept   = in_valid && in_ready;
  assign inflight = {1'b0, s1_valid} + {1'b0, out_valid};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_encrypt <= 1'b0;
      s1_data    <= '0;
      s1_mask    <= '0;
      s1_tag     <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_encrypt <= in_encrypt;
      s1_data    <= in_data;
      s1_mask    <= in_mask;
      s1_tag     <= in_tag;
    end else if (s1_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [BYTE_W-1:0] sub;

    sbox_lut u_lut (
      .value   (s1_data[BYTE_W*i +: BYTE_W]),
      .encrypt (s1_encrypt),
      .result  (sub)
    );

    // Masked-off lanes bypass the table untouched.
    assign lane_result[BYTE_W*i +: BYTE_W] = s1_mask[i] ? sub : s1_data[BYTE_W*i +: BYTE_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      // Data only moves with a real beat, so stale S1 contents never leak.
      if (s1_valid) begin
        out_data <= lane_result;
        out_tag  <= s1_tag;
      end
    end
  end

endmodule
`default_nettype wire
